// File: rtl/mux_4x1_operand_sequencer_pkg.sv
// Shared definitions for the mux_4x1 operand sequencer: FSM encodings and the default operand width.
package mux_4x1_operand_sequencer_pkg;

    localparam int SEQ_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mux_4x1_operand_sequencer_serial_shift_reg.sv
// W-bit load/shift register presenting one bit per shift, plus a one-bit delay flop for the previous bit.
// MUX_SEQ_MSB_FIRST_EN selects MSB-first order; LSB-first otherwise.
module serial_shift_reg #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_din,
    output logic         o_bit,
    output logic         o_pre
);

    logic [W-1:0] r_data;
    logic         r_pre;
    logic [W-1:0] w_shifted;

`ifdef MUX_SEQ_MSB_FIRST_EN
    assign o_bit     = r_data[W-1];
    assign w_shifted = {r_data[W-2:0], 1'b0};
`else
    assign o_bit     = r_data[0];
    assign w_shifted = {1'b0, r_data[W-1:1]};
`endif

    assign o_pre = r_pre;

    // The delay flop captures the bit being shifted out so pre tracks the previous presented bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data <= '0;
            r_pre  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_din;
            r_pre  <= 1'b0;
        end else if (i_shift) begin
            r_data <= w_shifted;
            r_pre  <= o_bit;
        end
    end

endmodule

// File: rtl/mux_4x1_operand_sequencer.sv
// Bit-serial operand feeder for mux_4x1: latches a/b/op on start, shifts one bit per clock, pulses done.
// Build option MUX_SEQ_MSB_FIRST_EN reverses the shift order (handled inside serial_shift_reg).
module mux_4x1_operand_sequencer
    import mux_4x1_operand_sequencer_pkg::*;
#(
    parameter int W = SEQ_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         s1,
    output logic         s2,
    output logic         inA,
    output logic         inB,
    output logic         pre_inA,
    output logic         pre_inB,
    output logic         bit_valid,
    output logic [3:0]   bit_idx,
    output logic         busy,
    output logic         done
);

    if (W < 2 || W > 16) begin : g_w_illegal
        $error("mux_4x1_operand_sequencer: W must be within 2..16");
    end

    localparam logic [3:0] LAST_IDX = 4'(W - 1);

    seq_state_t r_state, w_next;
    logic [1:0] r_op;
    logic [3:0] r_idx;
    logic       w_accept, w_shift;
    logic       w_bit_a, w_bit_b, w_pre_a, w_pre_b;

    serial_shift_reg #(.W(W)) u_sr_a (
        .i_clk   (clk),
        .i_reset (reset),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_din   (a),
        .o_bit   (w_bit_a),
        .o_pre   (w_pre_a)
    );

    serial_shift_reg #(.W(W)) u_sr_b (
        .i_clk   (clk),
        .i_reset (reset),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_din   (b),
        .o_bit   (w_bit_b),
        .o_pre   (w_pre_b)
    );

    // Index saturates at the last bit so it never exceeds W-1; it is cleared on the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= 2'b00;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op  <= op;
                r_idx <= 4'd0;
            end else if (w_shift && r_idx != LAST_IDX) begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_shift   = 1'b0;
        s1        = 1'b0;
        s2        = 1'b0;
        inA       = 1'b0;
        inB       = 1'b0;
        pre_inA   = 1'b0;
        pre_inB   = 1'b0;
        bit_valid = 1'b0;
        bit_idx   = 4'd0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift   = 1'b1;
                bit_valid = 1'b1;
                busy      = 1'b1;
                s1        = r_op[1];
                s2        = r_op[0];
                inA       = w_bit_a;
                inB       = w_bit_b;
                pre_inA   = w_pre_a;
                pre_inB   = w_pre_b;
                bit_idx   = r_idx;
                if (r_idx == LAST_IDX) w_next = ST_DONE;
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
